// File: rtl/pdm_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pdm_link_ctrl_if
// Purpose  : Stereo sample stream, valid/ready plus left/right words
// Revision : 1.0
// ============================================================================
interface pdm_link_ctrl_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] l;
  logic [W-1:0] r;

  modport master (output valid, l, r, input ready);
  modport slave  (input valid, l, r, output ready);
endinterface
`default_nettype wire

// File: rtl/pdm_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pdm_link_ctrl
// Purpose  : Stereo PDM link sequencer: ock generation, framing, TX/RX staging
// Revision : 1.0
// ============================================================================
module pdm_link_ctrl #(
  parameter int DIV_W   = 8,
  parameter int OSR_W   = 8,
  parameter int CAP_DLY = 3
) (
  input  wire              clk,
  input  wire              rstn,
  input  wire              cfg_en,
  input  wire  [DIV_W-1:0] cfg_div,
  input  wire  [OSR_W-1:0] cfg_osr,
  output logic             ock,
  output logic             busy,
  pdm_link_ctrl_if.slave   s,
  output logic [31:0]      din_l,
  output logic [31:0]      din_r,
  input  wire  [31:0]      dem_l,
  input  wire  [31:0]      dem_r,
  pdm_link_ctrl_if.master  m,
  input  wire              clr_err,
  output logic             underrun,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [31:0] c_mid = 32'h8000_0000;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div_q;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [OSR_W-1:0]   r_osr_q;
  logic [OSR_W-1:0]   r_bit_cnt;
  logic               r_tx_full;
  logic [31:0]        r_tx_l;
  logic [31:0]        r_tx_r;
  logic [CAP_DLY-1:0] r_cap_pipe;

  logic w_wrap, w_rise, w_tick, w_load, w_cap, w_ur, w_ov;

  // Ticks are only born in RUN; STOP just lets the high phase of ock finish.
  assign w_wrap = (r_div_cnt == r_div_q);
  assign w_rise = (r_state == RUN) && w_wrap && !ock;
  assign w_tick = w_rise && (r_bit_cnt == r_osr_q);
  assign w_load = s.valid && !r_tx_full;
  assign w_cap  = r_cap_pipe[CAP_DLY-1];
  assign w_ur   = w_tick && !r_tx_full;
  assign w_ov   = w_cap && m.valid && !m.ready;

  assign busy    = (r_state != IDLE);
  assign s.ready = !r_tx_full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      ock        <= 1'b0;
      r_div_q    <= '0;
      r_div_cnt  <= '0;
      r_osr_q    <= '0;
      r_bit_cnt  <= '0;
      r_tx_full  <= 1'b0;
      r_tx_l     <= c_mid;
      r_tx_r     <= c_mid;
      r_cap_pipe <= '0;
      din_l      <= c_mid;
      din_r      <= c_mid;
      m.valid    <= 1'b0;
      m.l        <= c_mid;
      m.r        <= c_mid;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          ock       <= 1'b0;
          if (cfg_en) begin
            r_state <= RUN;
            r_div_q <= cfg_div;
            r_osr_q <= cfg_osr;
          end
        end
        RUN: begin
          if (w_wrap) begin
            r_div_cnt <= '0;
            ock       <= ~ock;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
          if (w_rise)
            r_bit_cnt <= (r_bit_cnt == r_osr_q) ? '0 : r_bit_cnt + 1'b1;
          if (!cfg_en)
            r_state <= STOP;
        end
        STOP: begin
          if (!ock) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
          end else if (w_wrap) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            ock       <= 1'b0;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A full buffer blocks loads, so a tick drain and a load never collide.
      if (w_tick && r_tx_full) begin
        din_l     <= r_tx_l;
        din_r     <= r_tx_r;
        r_tx_full <= 1'b0;
      end
      if (w_load) begin
        r_tx_l    <= s.l;
        r_tx_r    <= s.r;
        r_tx_full <= 1'b1;
      end

      r_cap_pipe <= {r_cap_pipe[CAP_DLY-2:0], w_tick};
      if (w_cap) begin
        m.l     <= dem_l;
        m.r     <= dem_r;
        m.valid <= 1'b1;
      end else if (m.valid && m.ready) begin
        m.valid <= 1'b0;
      end

      underrun <= (underrun && !clr_err) || w_ur;
      overrun  <= (overrun && !clr_err) || w_ov;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pdm_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_link_ctrl
// Purpose  : Randomized scoreboard bench for pdm_link_ctrl
// Revision : 1.0
// ============================================================================
module tb_pdm_link_ctrl;

  localparam int          CAP_DLY = 3;
  localparam logic [31:0] c_mid   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_en = 1'b0;
  logic [7:0]  cfg_div = 8'd1;
  logic [7:0]  cfg_osr = 8'd3;
  logic        clr_err = 1'b0;
  logic [31:0] dem_l = '0;
  logic [31:0] dem_r = '0;
  logic        ock, busy, underrun, overrun;
  logic [31:0] din_l, din_r;

  pdm_link_ctrl_if tx_if ();
  pdm_link_ctrl_if rx_if ();

  pdm_link_ctrl #(.DIV_W(8), .OSR_W(8), .CAP_DLY(CAP_DLY)) dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_osr(cfg_osr),
    .ock(ock), .busy(busy), .s(tx_if.slave), .din_l(din_l), .din_r(din_r),
    .dem_l(dem_l), .dem_r(dem_r), .m(rx_if.master), .clr_err(clr_err),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: ock is a pure function of edges elapsed since RUN entry.
  int          n = 0;
  int          mode = 0;   // 0 idle, 1 run, 2 stop
  int          t0, dq, oq, e, k;
  bit          ock_m, mv_m, ur_m, ov_m, tick, ur_evt, ov_evt, was_empty;
  logic [63:0] din_m = {c_mid, c_mid};
  logic [63:0] txbuf[$];
  logic [63:0] din_exp[$];
  logic [63:0] rx_exp[$];
  int          cap_due[$];

  function automatic bit ock_at(int el);
    return ((el / (dq + 1)) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    n++;
    if (!rstn) begin
      mode = 0; ock_m = 0; mv_m = 0; ur_m = 0; ov_m = 0;
      txbuf.delete(); cap_due.delete(); rx_exp.delete();
      if (din_m != {c_mid, c_mid}) din_exp.push_back({c_mid, c_mid});
      din_m = {c_mid, c_mid};
    end else begin
      tick = 0; ur_evt = 0; ov_evt = 0;
      case (mode)
        0: begin
          ock_m = 0;
          if (cfg_en) begin mode = 1; t0 = n; dq = cfg_div; oq = cfg_osr; end
        end
        1: begin
          e = n - t0;
          ock_m = ock_at(e);
          if ((e % (dq + 1)) == 0 && ock_m) begin
            k = (e / (dq + 1) + 1) / 2;
            tick = (k % (oq + 1)) == 0;
          end
          if (!cfg_en) mode = 2;
        end
        default: begin
          if (!ock_m) mode = 0;
          else begin
            ock_m = ock_at(n - t0);
            if (!ock_m) mode = 0;
          end
        end
      endcase

      was_empty = (txbuf.size() == 0);
      if (tick) begin
        if (!was_empty) begin
          din_m = txbuf.pop_front();
          din_exp.push_back(din_m);
        end else ur_evt = 1;
      end
      if (tx_if.valid && was_empty) txbuf.push_back({tx_if.l, tx_if.r});

      if (cap_due.size() > 0 && cap_due[0] == n) begin
        void'(cap_due.pop_front());
        if (mv_m && !rx_if.ready) begin
          ov_evt = 1;
          if (rx_exp.size() > 0) void'(rx_exp.pop_back());
        end
        rx_exp.push_back({dem_l, dem_r});
        mv_m = 1;
      end else if (mv_m && rx_if.ready) mv_m = 0;
      if (tick) cap_due.push_back(n + CAP_DLY);

      ur_m = (ur_m && !clr_err) || ur_evt;
      ov_m = (ov_m && !clr_err) || ov_evt;
    end
  end

  // Monitor: lockstep control checks plus queue-based data scoreboard.
  bit          mon_en = 0;
  logic [63:0] din_prev = {c_mid, c_mid};
  logic [63:0] exp_v;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ock", ock, ock_m);
      chk("busy", busy, mode != 0);
      chk("s_ready", tx_if.ready, txbuf.size() == 0);
      chk("m_valid", rx_if.valid, mv_m);
      chk("underrun", underrun, ur_m);
      chk("overrun", overrun, ov_m);
      if ({din_l, din_r} !== din_prev) begin
        if (din_exp.size() == 0) chk("din_unexpected_change", {din_l, din_r}, din_prev);
        else begin
          exp_v = din_exp.pop_front();
          chk("din", {din_l, din_r}, exp_v);
        end
        din_prev = {din_l, din_r};
      end
      if (rx_if.valid && rx_if.ready) begin
        if (rx_exp.size() == 0) chk("rx_unexpected", 64'd1, 64'd0 + rx_exp.size());
        else begin
          exp_v = rx_exp.pop_front();
          chk("rx_data", {rx_if.l, rx_if.r}, exp_v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc();
    chk("rst_din", {din_l, din_r}, {c_mid, c_mid});
    chk("rst_m", {rx_if.l, rx_if.r}, {c_mid, c_mid});
    chk("rst_flags", {ock, busy, tx_if.ready, rx_if.valid, underrun, overrun}, 6'b001000);
    rstn = 1'b1;
  endtask

  task automatic rand_cycle();
    rstn         = ($urandom_range(999) >= 3);
    tx_if.valid  = ($urandom_range(99) < 40);
    tx_if.l      = $urandom;
    tx_if.r      = $urandom;
    dem_l        = $urandom;
    dem_r        = $urandom;
    rx_if.ready  = ($urandom_range(99) < 70);
    clr_err      = ($urandom_range(99) < 4);
    if ($urandom_range(99) < 5) cfg_div = 8'($urandom_range(0, 3));
    if ($urandom_range(99) < 5) cfg_osr = 8'($urandom_range(0, 5));
    if ($urandom_range(99) < 2) cfg_en = ~cfg_en;
    cyc();
  endtask

  initial begin
    tx_if.valid = 1'b0; tx_if.l = '0; tx_if.r = '0; rx_if.ready = 1'b1;
    do_reset();
    mon_en = 1;

    // Directed walk through the nominal sequence.
    cfg_div = 8'd1; cfg_osr = 8'd3; cfg_en = 1'b1;
    dem_l = 32'h8000_0010; dem_r = 32'h7FFF_FFF0;
    tx_if.l = 32'h4000_0000; tx_if.r = 32'hC000_0000; tx_if.valid = 1'b1;
    cyc();
    tx_if.valid = 1'b0;
    repeat (34) cyc();
    chk("dir_underrun", underrun, 1'b1);
    chk("dir_din_held", {din_l, din_r}, {32'h4000_0000, 32'hC000_0000});
    cfg_div = 8'd5;
    rx_if.ready = 1'b0;
    repeat (40) cyc();
    chk("dir_overrun", overrun, 1'b1);
    chk("dir_m_hold", {rx_if.l, rx_if.r}, {32'h8000_0010, 32'h7FFF_FFF0});
    clr_err = 1'b1; rx_if.ready = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("dir_clr", {underrun, overrun}, 2'b00);
    for (int i = 0; i < 100 && !ock; i++) cyc();
    chk("dir_wait_ock", ock, 1'b1);
    cfg_en = 1'b0;
    repeat (10) cyc();
    chk("dir_stopped", {busy, ock}, 2'b00);
    cfg_en = 1'b1; tx_if.valid = 1'b1; tx_if.l = 32'h1234_5678; tx_if.r = 32'h9ABC_DEF0;
    cyc();
    tx_if.valid = 1'b0;
    repeat (6) cyc();
    chk("dir_buf_full", tx_if.ready, 1'b0);
    do_reset();

    // Randomized phases across configurations.
    for (int p = 0; p < 12; p++) begin
      cfg_div = 8'($urandom_range(0, 3));
      cfg_osr = 8'($urandom_range(0, 5));
      cfg_en  = 1'b1;
      repeat ($urandom_range(50, 300)) rand_cycle();
      rstn = 1'b1; cfg_en = 1'b0; clr_err = 1'b0;
      repeat ($urandom_range(0, 30)) cyc();
    end

    // Drain so every predicted output has had a chance to appear.
    rstn = 1'b1; cfg_en = 1'b0; tx_if.valid = 1'b0; rx_if.ready = 1'b1; clr_err = 1'b0;
    repeat (60) cyc();
    chk("din_q_drained", 64'(din_exp.size()), 64'd0);
    chk("rx_q_drained", 64'(rx_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
